reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Consumer side of the register-invalid countdown used in the pipeline.
- Decode issues an instruction with a destination register and a latency count. Later instructions read per-register countdowns here to decide whether their sources are ready.
- Produces the decode-stage stall and a busy mask.
- Sits beside the register file, between decode and issue.

Parameters:
- NREG, 8, number of architectural registers.
- AW, 3, register address width; NREG == 2**AW.
- CW, 3, countdown width; max latency 2**CW-1.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all counters
- flush_decode  input  1  squash the instruction currently in decode
- issue_valid  input  1  decode holds an instruction that writes a register
- issue_dst  input  AW  destination register of that instruction
- issue_cnt  input  CW  cycles until the result is in the register file; 0 = no hazard
- src_a  input  AW  first source register
- src_a_use  input  1  src_a is actually read
- src_b  input  AW  second source register
- src_b_use  input  1  src_b is actually read
- wb_valid  input  1  early writeback/release
- wb_dst  input  AW  register released by wb_valid
- stall  output  1  decode must hold (combinational)
- busy_mask  output  NREG  bit r = 1 when cnt[r] != 0 (registered state)
- pend_a  output  CW  current cnt[src_a] (debug/forward select)

Behaviour:
- State: cnt[0..NREG-1], each CW bits. On reset (async) all are 0, so busy_mask=0, stall=0, pend_a=0.
- stall = (src_a_use & cnt[src_a] != 0) | (src_b_use & cnt[src_b] != 0). This is purely combinational from the current state and inputs.
- accept = issue_valid & ~stall & ~flush_decode.
- Per cycle, per register r, by priority (highest first):
  1. accept & issue_dst==r: cnt[r] <= issue_cnt. This overrides decrement and release.
  2. wb_valid & wb_dst==r: cnt[r] <= 0.
  3. cnt[r] != 0: cnt[r] <= cnt[r]-1.
  4. otherwise hold 0. Decrement saturates at 0 and never wraps.
- Latency: an issue in cycle t with issue_cnt=N makes busy_mask[dst]=1 from t+1. The counter reaches 0 at t+N+1, so a dependent source stalls for N cycles.
- flush_decode:
  - Blocks the current issue only.
  - Counters already running keep counting, because older instructions still complete.
  - stall is not forced low by flush.
- Issue while stalled: ignored. Decode re-presents the instruction, and the counter loads on the cycle stall drops.
- Issue to a register that is already busy (WAW): the new issue_cnt replaces the remaining count. No stall is raised for the destination.
- Source equal to issue_dst in the same cycle: uses the old count, with no self-hazard.
- wb_valid and accept to the same register in the same cycle: the issue wins.
- Reset mid-countdown: all counters clear immediately, asynchronously.

Optional Feature:
- Macro SCOREBOARD_FWD_EN.
- Defined: a bypass path exists, so a source whose count is exactly 1 does not stall. The stall condition per source becomes cnt > 1.
- Undefined: any nonzero count stalls, as specified above.
- Counter update rules are identical in both builds.

Test Plan:
- Reset release with src_a_use=1, src_a=2 -> stall=0, busy_mask=0x00.
- Issue dst=3, cnt=3 at t; src_a=3 used from t+1 -> busy_mask=0x08 at t+1..t+3; stall=1 at t+1..t+3, 0 at t+4. With SCOREBOARD_FWD_EN, stall=1 at t+1..t+2 only.
- Issue dst=5, cnt=4 with flush_decode=1 -> cnt[5] stays 0, busy_mask=0x00. Separately, an existing cnt[1]=2 continues 2->1->0 through the flush.
- cnt[4]=3; wb_valid, wb_dst=4 -> next cycle cnt[4]=0, busy_mask[4]=0. Repeat with a simultaneous accepted issue dst=4, cnt=4 -> cnt[4]=4.
- cnt[6]=2 with src_b=6 used and issue_valid dst=1, cnt=3 -> stall=1 and cnt[1] stays 0. When cnt[6] reaches 0, the issue is accepted and cnt[1]=3 next cycle.
- Assert reset while cnt[2]=4 and cnt[7]=1 mid-cycle -> busy_mask goes to 0x00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard: per-register latency countdowns that drive the decode stall and busy mask.
// Optional bypass build: define SCOREBOARD_FWD_EN so a source with count 1 no longer stalls.
module reg_scoreboard #(
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3,
    parameter int unsigned CW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_decode,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_dst,
    input  logic [CW-1:0]   issue_cnt,
    input  logic [AW-1:0]   src_a,
    input  logic            src_a_use,
    input  logic [AW-1:0]   src_b,
    input  logic            src_b_use,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_dst,
    output logic            stall,
    output logic [NREG-1:0] busy_mask,
    output logic [CW-1:0]   pend_a
);

    logic [CW-1:0] cnt_q [NREG];
    logic [CW-1:0] cnt_d [NREG];
    logic          accept;

    // A source count that still blocks the dependent instruction.
    function automatic logic hazard(input logic [CW-1:0] c);
`ifdef SCOREBOARD_FWD_EN
        return c > CW'(1);
`else
        return c != '0;
`endif
    endfunction

    always_comb begin
        stall  = (src_a_use & hazard(cnt_q[src_a])) | (src_b_use & hazard(cnt_q[src_b]));
        accept = issue_valid & ~stall & ~flush_decode;
        pend_a = cnt_q[src_a];
    end

    // Issue load beats writeback release, which beats the saturating decrement.
    always_comb begin
        for (int r = 0; r < int'(NREG); r++) begin
            cnt_d[r] = cnt_q[r];
            if (accept && issue_dst == AW'(r)) begin
                cnt_d[r] = issue_cnt;
            end else if (wb_valid && wb_dst == AW'(r)) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
    end

    always_comb begin
        for (int r = 0; r < int'(NREG); r++) begin
            busy_mask[r] = cnt_q[r] != '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs change and outputs are sampled on the falling edge.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush_decode, issue_valid, src_a_use, src_b_use, wb_valid;
    logic [2:0] issue_dst, issue_cnt, src_a, src_b, wb_dst;
    logic       stall;
    logic [7:0] busy_mask;
    logic [2:0] pend_a;

    int checks = 0;
    int errors = 0;

    reg_scoreboard dut (
        .clk          (clk),
        .reset        (reset),
        .flush_decode (flush_decode),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .issue_cnt    (issue_cnt),
        .src_a        (src_a),
        .src_a_use    (src_a_use),
        .src_b        (src_b),
        .src_b_use    (src_b_use),
        .wb_valid     (wb_valid),
        .wb_dst       (wb_dst),
        .stall        (stall),
        .busy_mask    (busy_mask),
        .pend_a       (pend_a)
    );

    always #5 clk = ~clk;

    task automatic idle();
        flush_decode = 1'b0; issue_valid = 1'b0; issue_dst = 3'd0; issue_cnt = 3'd0;
        src_a = 3'd0; src_a_use = 1'b0; src_b = 3'd0; src_b_use = 1'b0;
        wb_valid = 1'b0; wb_dst = 3'd0;
    endtask

    task automatic drain();
        idle();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        src_a = 3'd2; src_a_use = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL reset_busy got %h exp 00", busy_mask); end
        checks++; if (pend_a !== 3'd0) begin errors++; $display("FAIL reset_pend got %0d exp 0", pend_a); end
    endtask

    task automatic test_raw();
        logic [2:0] c;
        logic       exp_stall;
        idle();
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd3; issue_cnt = 3'd3;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            issue_valid = 1'b0; src_a = 3'd3; src_a_use = 1'b1;
            #1;
            c = 3'(3 - k);
            exp_stall = FWD ? (c > 3'd1) : (c != 3'd0);
            checks++; if (busy_mask !== ((c != 3'd0) ? 8'h08 : 8'h00)) begin errors++; $display("FAIL raw_busy k=%0d got %h", k, busy_mask); end
            checks++; if (stall !== exp_stall) begin errors++; $display("FAIL raw_stall k=%0d got %b exp %b", k, stall, exp_stall); end
            checks++; if (pend_a !== c) begin errors++; $display("FAIL raw_pend k=%0d got %0d exp %0d", k, pend_a, c); end
        end
        drain();
    endtask

    task automatic test_flush();
        idle();
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd1; issue_cnt = 3'd2;
        @(negedge clk);
        issue_dst = 3'd5; issue_cnt = 3'd4; flush_decode = 1'b1; src_a = 3'd1;
        #1;
        checks++; if (pend_a !== 3'd2) begin errors++; $display("FAIL flush_pend0 got %0d exp 2", pend_a); end
        checks++; if (busy_mask !== 8'h02) begin errors++; $display("FAIL flush_busy0 got %h exp 02", busy_mask); end
        @(negedge clk);
        issue_valid = 1'b0; flush_decode = 1'b0;
        #1;
        checks++; if (pend_a !== 3'd1) begin errors++; $display("FAIL flush_pend1 got %0d exp 1", pend_a); end
        checks++; if (busy_mask !== 8'h02) begin errors++; $display("FAIL flush_busy1 got %h exp 02", busy_mask); end
        @(negedge clk);
        #1;
        checks++; if (pend_a !== 3'd0) begin errors++; $display("FAIL flush_pend2 got %0d exp 0", pend_a); end
        checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL flush_busy2 got %h exp 00", busy_mask); end
        drain();
    endtask

    task automatic test_wb();
        idle();
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd4; issue_cnt = 3'd3; src_a = 3'd4;
        @(negedge clk);
        issue_valid = 1'b0; wb_valid = 1'b1; wb_dst = 3'd4;
        #1;
        checks++; if (pend_a !== 3'd3) begin errors++; $display("FAIL wb_pend0 got %0d exp 3", pend_a); end
        @(negedge clk);
        wb_valid = 1'b0;
        #1;
        checks++; if (pend_a !== 3'd0) begin errors++; $display("FAIL wb_pend1 got %0d exp 0", pend_a); end
        checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL wb_busy1 got %h exp 00", busy_mask); end
        issue_valid = 1'b1; issue_cnt = 3'd3;
        @(negedge clk);
        issue_cnt = 3'd4; wb_valid = 1'b1; wb_dst = 3'd4;
        @(negedge clk);
        issue_valid = 1'b0; wb_valid = 1'b0;
        #1;
        checks++; if (pend_a !== 3'd4) begin errors++; $display("FAIL wb_issue_pend got %0d exp 4", pend_a); end
        checks++; if (busy_mask !== 8'h10) begin errors++; $display("FAIL wb_issue_busy got %h exp 10", busy_mask); end
        drain();
    endtask

    task automatic test_stall_issue();
        idle();
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd6; issue_cnt = 3'd2;
        @(negedge clk);
        issue_dst = 3'd1; issue_cnt = 3'd3; src_b = 3'd6; src_b_use = 1'b1; src_a = 3'd1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stl_stall0 got %b exp 1", stall); end
        checks++; if (pend_a !== 3'd0) begin errors++; $display("FAIL stl_pend0 got %0d exp 0", pend_a); end
        @(negedge clk);
        #1;
        checks++; if (stall !== !FWD) begin errors++; $display("FAIL stl_stall1 got %b exp %b", stall, !FWD); end
        checks++; if (pend_a !== 3'd0) begin errors++; $display("FAIL stl_pend1 got %0d exp 0", pend_a); end
        @(negedge clk);
        #1;
        checks++; if (pend_a !== (FWD ? 3'd3 : 3'd0)) begin errors++; $display("FAIL stl_pend2 got %0d", pend_a); end
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        checks++; if (pend_a !== 3'd3) begin errors++; $display("FAIL stl_pend3 got %0d exp 3", pend_a); end
        checks++; if (busy_mask !== 8'h02) begin errors++; $display("FAIL stl_busy3 got %h exp 02", busy_mask); end
        drain();
    endtask

    task automatic test_async_reset();
        idle();
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd7; issue_cnt = 3'd2;
        @(negedge clk);
        issue_dst = 3'd2; issue_cnt = 3'd4;
        @(negedge clk);
        issue_valid = 1'b0; src_a = 3'd2;
        #1;
        checks++; if (busy_mask !== 8'h84) begin errors++; $display("FAIL arst_pre got %h exp 84", busy_mask); end
        checks++; if (pend_a !== 3'd4) begin errors++; $display("FAIL arst_pre_pend got %0d exp 4", pend_a); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (busy_mask !== 8'h00) begin errors++; $display("FAIL arst_busy got %h exp 00", busy_mask); end
        checks++; if (pend_a !== 3'd0) begin errors++; $display("FAIL arst_pend got %0d exp 0", pend_a); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_flush();
        test_wb();
        test_stall_issue();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
